// File: rtl/attitude_angle_seq.sv
`default_nettype none
// ============================================================================
// Module   : attitude_angle_seq
// Brief    : Sequences two jobs on a shared cordic_angle instance per
//            accelerometer sample: pitch with (ax, ay, az), then roll with
//            (ay, ax, az). Both angles are published together with a
//            one-cycle angle_valid pulse. Samples arriving while a job is in
//            flight are dropped and counted in a saturating overrun counter.
// Options  : ATT_SEQ_TIMEOUT_EN - when defined, each wait for cdra_done is
//            bounded by TIMEOUT_CYCLES. Expiry sets sticky err_timeout and
//            abandons the job. When undefined, waits are unbounded and
//            err_timeout is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module attitude_angle_seq #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] ax,
  input  logic signed [15:0] ay,
  input  logic signed [15:0] az,
  input  logic               sample_valid,
  output logic signed [15:0] cdr_x,
  output logic signed [15:0] cdr_y,
  output logic signed [15:0] cdr_z,
  output logic               cdra_start,
  input  logic               cdra_done,
  input  logic signed [15:0] crda_angle,
  output logic signed [15:0] pitch,
  output logic signed [15:0] roll,
  output logic               angle_valid,
  output logic               busy,
  output logic [7:0]         overrun_cnt,
  output logic               err_timeout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P_START = 3'd1,
    P_WAIT  = 3'd2,
    R_START = 3'd3,
    R_WAIT  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;

  // Sample captured at acceptance; the operands are driven from these so
  // that later sample_valid pulses cannot disturb an in-flight job.
  logic signed [15:0] r_ax_l;
  logic signed [15:0] r_ay_l;
  logic signed [15:0] r_az_l;

  // Results are staged here so pitch/roll only ever change as a pair.
  logic signed [15:0] r_pitch_tmp;
  logic signed [15:0] r_roll_tmp;
  logic signed [15:0] r_pitch;
  logic signed [15:0] r_roll;
  logic               r_angle_valid;
  logic [7:0]         r_overrun;

  // Asserted by the next-state logic when a wait expires (only ever set in
  // the timeout-enabled build).
  logic               w_timeout;

`ifdef ATT_SEQ_TIMEOUT_EN
  localparam int c_TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_TCNT_W-1:0] c_TCNT_LAST = c_TCNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_TCNT_W-1:0] r_tcnt;
  logic                r_err_timeout;
  logic                w_tcnt_hit;

  // The final permitted wait cycle is reached when the counter, which starts
  // at 0 on entry to a wait state, has counted TIMEOUT_CYCLES-1 cycles.
  assign w_tcnt_hit = (r_tcnt == c_TCNT_LAST);
`endif

  // Next-state decode and Moore outputs; operands are held for the whole
  // start-to-done window of each job and are zero when no job is active.
  always_comb begin
    w_next     = r_state;
    w_timeout  = 1'b0;
    cdr_x      = '0;
    cdr_y      = '0;
    cdr_z      = '0;
    cdra_start = 1'b0;
    busy       = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (sample_valid) begin
          w_next = P_START;
        end
      end

      P_START: begin
        cdr_x      = r_ax_l;
        cdr_y      = r_ay_l;
        cdr_z      = r_az_l;
        cdra_start = 1'b1;
        w_next     = P_WAIT;
      end

      P_WAIT: begin
        cdr_x = r_ax_l;
        cdr_y = r_ay_l;
        cdr_z = r_az_l;
        if (cdra_done) begin
          w_next = R_START;
        end
`ifdef ATT_SEQ_TIMEOUT_EN
        else if (w_tcnt_hit) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
`endif
      end

      R_START: begin
        cdr_x      = r_ay_l;
        cdr_y      = r_ax_l;
        cdr_z      = r_az_l;
        cdra_start = 1'b1;
        w_next     = R_WAIT;
      end

      R_WAIT: begin
        cdr_x = r_ay_l;
        cdr_y = r_ax_l;
        cdr_z = r_az_l;
        if (cdra_done) begin
          w_next = DONE;
        end
`ifdef ATT_SEQ_TIMEOUT_EN
        else if (w_tcnt_hit) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
`endif
      end

      DONE: begin
        w_next = IDLE;
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register; reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Sample latch: only an IDLE-state strobe is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ax_l <= '0;
      r_ay_l <= '0;
      r_az_l <= '0;
    end else if (r_state == IDLE && sample_valid) begin
      r_ax_l <= ax;
      r_ay_l <= ay;
      r_az_l <= az;
    end
  end

  // Capture each cordic result only in its matching wait state, so a stray
  // or late cdra_done elsewhere has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pitch_tmp <= '0;
      r_roll_tmp  <= '0;
    end else begin
      if (r_state == P_WAIT && cdra_done) begin
        r_pitch_tmp <= crda_angle;
      end
      if (r_state == R_WAIT && cdra_done) begin
        r_roll_tmp <= crda_angle;
      end
    end
  end

  // Publish both angles together on leaving DONE, with a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pitch       <= '0;
      r_roll        <= '0;
      r_angle_valid <= 1'b0;
    end else begin
      r_angle_valid <= (r_state == DONE);
      if (r_state == DONE) begin
        r_pitch <= r_pitch_tmp;
        r_roll  <= r_roll_tmp;
      end
    end
  end

  // Count samples dropped while busy (DONE included), saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= '0;
    end else if (sample_valid && r_state != IDLE && r_overrun != 8'hFF) begin
      r_overrun <= r_overrun + 8'd1;
    end
  end

`ifdef ATT_SEQ_TIMEOUT_EN
  // Wait-cycle counter: runs while remaining in P_WAIT/R_WAIT and is held
  // at 0 everywhere else, so each wait starts counting from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if ((r_state == P_WAIT || r_state == R_WAIT) && (w_next == r_state)) begin
      r_tcnt <= r_tcnt + 1'b1;
    end else begin
      r_tcnt <= '0;
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_err_timeout <= 1'b1;
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign err_timeout = 1'b0;
`endif

  assign pitch       = r_pitch;
  assign roll        = r_roll;
  assign angle_valid = r_angle_valid;
  assign overrun_cnt = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_attitude_angle_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_attitude_angle_seq
// Brief    : Directed, scoreboard-based bench for attitude_angle_seq with a
//            behavioural cordic_angle model (fixed latency, optional hang).
// Revision : 1.0 - initial release
// ============================================================================
module tb_attitude_angle_seq;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } ops_t;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] ax, ay, az;
  logic               sample_valid;
  logic signed [15:0] cdr_x, cdr_y, cdr_z;
  logic               cdra_start;
  logic               cdra_done;
  logic signed [15:0] crda_angle;
  logic signed [15:0] pitch, roll;
  logic               angle_valid;
  logic               busy;
  logic [7:0]         overrun_cnt;
  logic               err_timeout;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Cordic model state
  logic               m_done   = 1'b0;
  logic               m_active = 1'b0;
  logic signed [15:0] m_angle  = '0;
  int                 m_left   = 0;
  int                 m_lat    = 18;
  bit                 m_hang   = 1'b0;
  logic signed [15:0] m_ax     = '0;
  logic signed [15:0] m_p      = '0;
  logic signed [15:0] m_r      = '0;
  logic               spur     = 1'b0;

  // Scoreboard
  ops_t        op_q[$];
  logic [31:0] res_q[$];
  int          n_start = 0;
  int          n_av    = 0;
  int          av_cyc  = 0;
  int          first_start_cyc = 0;
  bit          cap_first = 1'b0;
  int          sv_cyc  = 0;
  ops_t        last_op = '0;

  attitude_angle_seq #(
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ax          (ax),
    .ay          (ay),
    .az          (az),
    .sample_valid(sample_valid),
    .cdr_x       (cdr_x),
    .cdr_y       (cdr_y),
    .cdr_z       (cdr_z),
    .cdra_start  (cdra_start),
    .cdra_done   (cdra_done),
    .crda_angle  (crda_angle),
    .pitch       (pitch),
    .roll        (roll),
    .angle_valid (angle_valid),
    .busy        (busy),
    .overrun_cnt (overrun_cnt),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Cordic model: done arrives m_lat cycles after the start cycle. The pitch
  // job is recognised by cdr_x matching the accepted sample's ax.
  assign cdra_done  = m_done | spur;
  assign crda_angle = m_angle;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (m_active) begin
      if (m_left == 1) begin
        m_done   <= 1'b1;
        m_active <= 1'b0;
      end
      m_left <= m_left - 1;
    end else if (cdra_start && !m_hang) begin
      m_active <= 1'b1;
      m_left   <= m_lat - 1;
      m_angle  <= (cdr_x == m_ax) ? m_p : m_r;
    end
  end

  task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic chk48(input string tag, input logic [47:0] got, input logic [47:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Drive an accepted sample for one cycle and record what it must produce.
  task automatic send(input logic signed [15:0] x, y, z, p, r, input bit full);
    ax = x; ay = y; az = z;
    sample_valid = 1'b1;
    sv_cyc = cyc;
    m_ax = x; m_p = p; m_r = r;
    cap_first = 1'b1;
    op_q.push_back({x, y, z});
    if (full) begin
      op_q.push_back({y, x, z});
      res_q.push_back({p, r});
    end
    step();
    sample_valid = 1'b0;
  endtask

  // Drive a sample that the DUT must drop.
  task automatic pulse(input logic signed [15:0] x, y, z);
    ax = x; ay = y; az = z;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic wait_av(input int budget);
    int n0 = n_av;
    int k  = 0;
    while (n_av == n0 && k < budget) begin
      step();
      k++;
    end
    tests++;
    assert (n_av != n0) else begin
      fails++;
      $error("FAIL av_wait: observed=no angle_valid in %0d cycles expected=angle_valid", budget);
    end
  endtask

  initial begin
    int n0;
    int s0;
    ops_t e_op;

    rst = 1'b1; sample_valid = 1'b0; ax = '0; ay = '0; az = '0;

    // Monitor: checks operands at each start, operand stability at each done,
    // and angles at each angle_valid against the scoreboard.
    fork
      forever begin
        @(negedge clk);
        if (cdra_start) begin
          n_start++;
          if (cap_first) begin
            first_start_cyc = cyc;
            cap_first = 1'b0;
          end
          last_op = {cdr_x, cdr_y, cdr_z};
          if (op_q.size() == 0) begin
            tests++; fails++;
            $error("FAIL start_unexpected: observed=%h expected=no start", last_op);
          end else begin
            e_op = op_q.pop_front();
            chk48("start_ops", last_op, e_op);
          end
        end
        if (cdra_done && busy) begin
          chk48("ops_stable", {cdr_x, cdr_y, cdr_z}, last_op);
        end
        if (angle_valid) begin
          n_av++;
          av_cyc = cyc;
          if (res_q.size() == 0) begin
            tests++; fails++;
            $error("FAIL av_unexpected: observed=%0d/%0d expected=no angle_valid", pitch, roll);
          end else begin
            chk48("angles", {16'h0, pitch, roll}, {16'h0, res_q.pop_front()});
          end
        end
      end
    join_none

    // Reset with random inputs
    repeat (5) begin
      step();
      ax = 16'($urandom); ay = 16'($urandom); az = 16'($urandom);
      sample_valid = 1'($urandom_range(0, 1));
    end
    sample_valid = 1'b1;
    step();
    chk16("rst_pitch", pitch, 16'd0);
    chk16("rst_roll", roll, 16'd0);
    chk16("rst_av", {15'd0, angle_valid}, 16'd0);
    chk16("rst_busy", {15'd0, busy}, 16'd0);
    chk16("rst_ovr", {8'd0, overrun_cnt}, 16'd0);
    chk16("rst_err", {15'd0, err_timeout}, 16'd0);
    chk48("rst_ops", {cdr_x, cdr_y, cdr_z}, 48'd0);
    chk16("rst_start", {15'd0, cdra_start}, 16'd0);
    rst = 1'b0; sample_valid = 1'b0;
    step();
    chk16("post_rst_busy", {15'd0, busy}, 16'd0);

    // Nominal job with latency checks
    s0 = n_start; n0 = n_av;
    send(16'sd11585, 16'sd0, 16'sd10000, 16'sd3930, 16'sd0, 1'b1);
    wait_av(100);
    chk16("p_start_lat", 16'(first_start_cyc - sv_cyc), 16'd1);
    chk16("av_lat", 16'(av_cyc - sv_cyc), 16'd40);
    chk16("nom_pitch", pitch, 16'sd3930);
    chk16("nom_roll", roll, 16'sd0);
    repeat (3) step();
    chk16("nom_starts", 16'(n_start - s0), 16'd2);
    chk16("nom_av_once", 16'(n_av - n0), 16'd1);
    chk16("nom_idle", {15'd0, busy}, 16'd0);

    // Second pattern with negative values
    send(-16'sd5000, 16'sd12000, -16'sd8000, -16'sd1234, 16'sd2222, 1'b1);
    wait_av(100);
    chk16("p2_pitch", pitch, -16'sd1234);
    chk16("p2_roll", roll, 16'sd2222);

    // Three overruns during one job
    step();
    send(16'sd1000, 16'sd2000, 16'sd3000, 16'sd111, 16'sd222, 1'b1);
    repeat (5) step();
    pulse(16'sd1, 16'sd2, 16'sd3);
    repeat (9) step();
    pulse(16'sd4, 16'sd5, 16'sd6);
    repeat (9) step();
    pulse(16'sd7, 16'sd8, 16'sd9);
    wait_av(100);
    chk16("ovr3_cnt", {8'd0, overrun_cnt}, 16'd3);
    chk16("ovr3_pitch", pitch, 16'sd111);

    // Sample in DONE is dropped; sample in the following IDLE is accepted
    step();
    send(16'sd300, -16'sd400, 16'sd500, -16'sd77, 16'sd88, 1'b1);
    while (cyc < sv_cyc + 39) step();
    chk16("done_busy", {15'd0, busy}, 16'd1);
    pulse(16'sd1, 16'sd1, 16'sd1);
    chk16("done_av", {15'd0, angle_valid}, 16'd1);
    chk16("done_ovr", {8'd0, overrun_cnt}, 16'd4);
    send(-16'sd20000, 16'sd15000, 16'sd1, 16'sd999, -16'sd999, 1'b1);
    wait_av(100);
    chk16("after_done_pitch", pitch, 16'sd999);
    chk16("after_done_roll", roll, -16'sd999);

    // Saturation of the overrun counter
    step();
    m_lat = 400;
    send(16'sd1, 16'sd2, 16'sd3, 16'sd10, 16'sd20, 1'b1);
    repeat (300) pulse(16'sd5, 16'sd5, 16'sd5);
    m_lat = 18;
    chk16("ovr_sat", {8'd0, overrun_cnt}, 16'd255);
    wait_av(1000);
    chk16("sat_pitch", pitch, 16'sd10);
    chk16("sat_roll", roll, 16'sd20);

    // Spurious done in IDLE
    step();
    s0 = n_start; n0 = n_av;
    spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (3) step();
    chk16("spur_busy", {15'd0, busy}, 16'd0);
    chk16("spur_pitch", pitch, 16'sd10);
    chk16("spur_roll", roll, 16'sd20);
    chk16("spur_no_av", 16'(n_av - n0), 16'd0);
    chk16("spur_no_start", 16'(n_start - s0), 16'd0);

    // Reset during R_WAIT; the model's late done must be ignored
    send(16'sd7000, -16'sd3000, 16'sd2000, 16'sd500, 16'sd600, 1'b1);
    while (cyc < sv_cyc + 25) step();
    chk16("mid_busy", {15'd0, busy}, 16'd1);
    n0 = n_av;
    rst = 1'b1;
    step();
    rst = 1'b0;
    res_q.delete();
    chk16("mid_rst_busy", {15'd0, busy}, 16'd0);
    chk16("mid_rst_ovr", {8'd0, overrun_cnt}, 16'd0);
    while (cyc < sv_cyc + 45) step();
    chk16("mid_no_av", 16'(n_av - n0), 16'd0);
    chk16("mid_pitch", pitch, 16'sd0);
    chk16("mid_roll", roll, 16'sd0);
    chk16("mid_late_busy", {15'd0, busy}, 16'd0);
    send(-16'sd9000, 16'sd4000, -16'sd100, -16'sd321, 16'sd123, 1'b1);
    wait_av(100);
    chk16("mid_next_pitch", pitch, -16'sd321);
    chk16("mid_next_roll", roll, 16'sd123);

`ifdef ATT_SEQ_TIMEOUT_EN
    // Timeout: model never answers the pitch job
    step();
    n0 = n_av;
    m_hang = 1'b1;
    send(16'sd123, 16'sd456, 16'sd789, 16'sd0, 16'sd0, 1'b0);
    while (cyc < sv_cyc + 51) step();
    chk16("to_err_before", {15'd0, err_timeout}, 16'd0);
    chk16("to_busy_before", {15'd0, busy}, 16'd1);
    step();
    chk16("to_err", {15'd0, err_timeout}, 16'd1);
    chk16("to_idle", {15'd0, busy}, 16'd0);
    chk16("to_pitch", pitch, -16'sd321);
    chk16("to_roll", roll, 16'sd123);
    chk16("to_no_av", 16'(n_av - n0), 16'd0);
    m_hang = 1'b0;
    step();
    send(16'sd2000, -16'sd1000, 16'sd3000, 16'sd4321, -16'sd4321, 1'b1);
    wait_av(100);
    chk16("to_next_pitch", pitch, 16'sd4321);
    chk16("to_err_sticky", {15'd0, err_timeout}, 16'd1);
`else
    chk16("err_tied", {15'd0, err_timeout}, 16'd0);
`endif

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/attitude_angle_seq.md
ATTITUDE_ANGLE_SEQ -- requirements
Module: attitude_angle_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles waited for cdra_done per job.
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ax, ay, az  input  16 each, signed  accelerometer sample (1g = 16384).
REQ-005 SHALL have port sample_valid  input  1  one-cycle sample strobe.
REQ-006 SHALL have port cdr_x, cdr_y, cdr_z  output  16 each, signed  operands to the shared cordic_angle instance.
REQ-007 SHALL have port cdra_start  output  1  one-cycle start pulse to cordic_angle.
REQ-008 SHALL have port cdra_done  input  1  completion strobe from cordic_angle.
REQ-009 SHALL have port crda_angle  input  16, signed  cordic_angle result.
REQ-010 SHALL have port pitch, roll  output  16 each, signed  latest angles, cordic units.
REQ-011 SHALL have port angle_valid  output  1  one-cycle pulse when pitch and roll both updated.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port overrun_cnt  output  8  saturating count of dropped samples.
REQ-014 SHALL have port err_timeout  output  1  sticky timeout flag.

Function
REQ-015 SHALL implement states IDLE, P_START, P_WAIT, R_START, R_WAIT, DONE.
REQ-016 IDLE: sample_valid high SHALL latch ax/ay/az into internal registers and go to P_START next cycle.
REQ-017 P_START SHALL drive cdr_x=ax_l, cdr_y=ay_l, cdr_z=az_l, assert cdra_start for exactly one cycle, go to P_WAIT.
REQ-018 P_WAIT: cdra_done high SHALL capture crda_angle into pitch_tmp and go to R_START.
REQ-019 R_START SHALL drive cdr_x=ay_l, cdr_y=ax_l, cdr_z=az_l, pulse cdra_start one cycle, go to R_WAIT.
REQ-020 R_WAIT: cdra_done high SHALL capture crda_angle into roll_tmp and go to DONE.
REQ-021 DONE SHALL copy pitch_tmp/roll_tmp to pitch/roll, pulse angle_valid one cycle, return to IDLE.
REQ-022 cdr_x/y/z SHALL stay stable from the start cycle until the matching cdra_done cycle.
REQ-023 Latency SHALL be: sample_valid at cycle T, pitch start at T+1; angle_valid exactly 2 cycles after the roll cdra_done cycle.
REQ-024 pitch/roll SHALL change only in DONE; both update together, never one alone.
REQ-025 sample_valid while busy SHALL be ignored (no latch) and increment overrun_cnt, saturating at 255.
REQ-026 sample_valid in the DONE cycle SHALL count as overrun; in IDLE the cycle after DONE it SHALL be accepted.
REQ-027 cdra_done in IDLE, P_START, R_START or DONE SHALL be ignored.
REQ-028 cdra_start SHALL never be asserted while a job is outstanding.

Reset
REQ-029 rst high at a clock edge SHALL force state IDLE, cdr_x/y/z=0, cdra_start=0, pitch=0, roll=0, angle_valid=0, busy=0, overrun_cnt=0, err_timeout=0, timeout counter=0.
REQ-030 rst mid-job SHALL abort it without updating pitch/roll; a late cdra_done after reset SHALL be ignored.
REQ-031 rst SHALL override sample_valid in the same cycle.

Configuration
REQ-032 Macro ATT_SEQ_TIMEOUT_EN defined: a counter SHALL run in P_WAIT/R_WAIT; reaching TIMEOUT_CYCLES without cdra_done SHALL set err_timeout, discard the job (no angle_valid, pitch/roll held), return to IDLE.
REQ-033 err_timeout SHALL clear only on rst; the counter SHALL restart at 0 at each P_WAIT/R_WAIT entry.
REQ-034 Macro undefined: no counter, err_timeout tied 0, P_WAIT/R_WAIT wait indefinitely.

Verification
REQ-035 Reset check: rst high 5 cycles with random inputs -> all outputs 0, busy=0.
REQ-036 Nominal: cordic model, 18-cycle latency, returns 3930 pitch / 0 roll; ax=11585, ay=0, az=10000 -> two starts with swapped x/y, angle_valid once, pitch=3930, roll=0.
REQ-037 Overrun: 3 sample_valid pulses during one job -> overrun_cnt=3, one angle_valid, operands from first sample only; 300 pulses while busy -> overrun_cnt=255.
REQ-038 Timeout (ATT_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=50): model never asserts done -> err_timeout=1 after 50 wait cycles, no angle_valid, returns to IDLE, pitch/roll unchanged.
REQ-039 Mid-job reset: rst in R_WAIT then model's done -> no angle_valid, pitch/roll=0, next sample completes normally.
REQ-040 Spurious done: cdra_done pulsed in IDLE -> no state change, no output change.
